// File: rtl/tff_bank_if.sv
// Control/data bundle for tff_bank: update controls and operands in,
// stored bits, change flags and flip statistics out.
interface tff_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) ();
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] changed;
  logic [CNT_W-1:0] flip_cnt;
  logic             cnt_sat;
  logic             sr_err;

  modport master (
    output en, mode, a, b, cnt_clr,
    input  q, changed, flip_cnt, cnt_sat, sr_err
  );

  modport slave (
    input  en, mode, a, b, cnt_clr,
    output q, changed, flip_cnt, cnt_sat, sr_err
  );
endinterface

// File: rtl/tff_bank.sv
// Bank of WIDTH storage bits with runtime-selected T/D/JK/SR behaviour,
// per-edge change flags, a saturating flip counter and a sticky SR-illegal flag.
module tff_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic       clk,
  input logic       reset,
  tff_bank_if.slave bus
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((POP_W > CNT_W) ? POP_W : CNT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_T  = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic             sr_err_q, sr_err_d;

  logic             sr_hit;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;

  // Per-bit next state for the selected mode
  always_comb begin
    q_d    = q_q;
    sr_hit = 1'b0;
    if (bus.en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        unique case (bus.mode)
          MODE_T:  q_d[i] = q_q[i] ^ bus.a[i];
          MODE_D:  q_d[i] = bus.a[i];
          MODE_JK: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_SR: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   sr_hit = 1'b1;
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  // Change flags, flip statistics and sticky flags; a clear beats same-edge events
  always_comb begin
    changed_d = q_d ^ q_q;
    pop       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(changed_d[i]);
    end
    sum      = SUM_W'(flip_cnt_q) + SUM_W'(pop);
    cnt_next = (sum >= SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

    flip_cnt_d = cnt_next;
    cnt_sat_d  = cnt_sat_q | (cnt_next == CNT_MAX);
    sr_err_d   = sr_err_q | sr_hit;
    if (bus.cnt_clr) begin
      flip_cnt_d = '0;
      cnt_sat_d  = 1'b0;
      sr_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q        <= '0;
      changed_q  <= '0;
      flip_cnt_q <= '0;
      cnt_sat_q  <= 1'b0;
      sr_err_q   <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      flip_cnt_q <= flip_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
      sr_err_q   <= sr_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.changed  = changed_q;
  assign bus.flip_cnt = flip_cnt_q;
  assign bus.cnt_sat  = cnt_sat_q;
  assign bus.sr_err   = sr_err_q;

endmodule

// File: tb/tb_tff_bank.sv
// Bench for tff_bank: two instances (CNT_W=16 and CNT_W=4) driven identically,
// checked against directed expectations and a behavioural reference model.
module tb_tff_bank;

  localparam logic [1:0] T = 2'b00, D = 2'b01, JK = 2'b10, SR = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  tff_bank_if #(.WIDTH(8), .CNT_W(16)) if16 ();
  tff_bank_if #(.WIDTH(8), .CNT_W(4))  if4 ();

  tff_bank #(.WIDTH(8), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  tff_bank #(.WIDTH(8), .CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [7:0] m_q, m_ch;
  int         m_cnt16, m_cnt4;
  logic       m_sat16, m_sat4, m_err;

  function automatic logic [55:0] obs_all();
    return {if16.q, if16.changed, if16.flip_cnt, if16.cnt_sat, if16.sr_err,
            if4.q, if4.changed, if4.flip_cnt, if4.cnt_sat, if4.sr_err};
  endfunction

  function automatic logic [55:0] exp_all();
    return {m_q, m_ch, 16'(m_cnt16), m_sat16, m_err,
            m_q, m_ch, 4'(m_cnt4), m_sat4, m_err};
  endfunction

  // Drive one edge on both instances and advance the reference model
  task automatic step(input logic rst_i, input logic en_i, input logic [1:0] mode_i,
                      input logic [7:0] a_i, input logic [7:0] b_i, input logic clr_i);
    logic [7:0] nq;
    logic       illegal;
    int         n;
    reset = rst_i;
    if16.en = en_i; if16.mode = mode_i; if16.a = a_i; if16.b = b_i; if16.cnt_clr = clr_i;
    if4.en  = en_i; if4.mode  = mode_i; if4.a  = a_i; if4.b  = b_i; if4.cnt_clr  = clr_i;
    @(posedge clk);
    if (!rst_i) begin
      m_q = '0; m_ch = '0; m_cnt16 = 0; m_cnt4 = 0;
      m_sat16 = 1'b0; m_sat4 = 1'b0; m_err = 1'b0;
    end else begin
      nq = m_q;
      illegal = 1'b0;
      if (en_i) begin
        case (mode_i)
          T: nq = m_q ^ a_i;
          D: nq = a_i;
          JK: nq = (m_q & ~b_i) | (~m_q & a_i);
          default: begin
            nq = (m_q | (a_i & ~b_i)) & ~(b_i & ~a_i);
            illegal = (a_i & b_i) != 8'h00;
          end
        endcase
      end
      m_ch = nq ^ m_q;
      m_q  = nq;
      n    = $countones(m_ch);
      if (clr_i) begin
        m_cnt16 = 0; m_cnt4 = 0; m_sat16 = 1'b0; m_sat4 = 1'b0; m_err = 1'b0;
      end else begin
        m_cnt16 = (m_cnt16 + n > 65535) ? 65535 : m_cnt16 + n;
        m_cnt4  = (m_cnt4 + n > 15) ? 15 : m_cnt4 + n;
        m_sat16 = m_sat16 | (m_cnt16 == 65535);
        m_sat4  = m_sat4 | (m_cnt4 == 15);
        m_err   = m_err | illegal;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, T, 8'hFF, 8'h00, 1'b0);
      checks++;
      if ({if16.q, if16.changed, if16.flip_cnt, if4.flip_cnt} !== 36'h0) begin
        failures++;
        $display("FAIL reset_hold%0d got q=%h ch=%h cnt=%h cnt4=%h expected all zero",
                 i, if16.q, if16.changed, if16.flip_cnt, if4.flip_cnt);
      end
    end
    step(1'b1, 1'b1, T, 8'hFF, 8'h00, 1'b0);
    checks++;
    if (if16.q !== 8'hFF || if16.changed !== 8'hFF || if16.flip_cnt !== 16'd8) begin
      failures++;
      $display("FAIL release1 got q=%h ch=%h cnt=%0d expected q=ff ch=ff cnt=8",
               if16.q, if16.changed, if16.flip_cnt);
    end
    step(1'b1, 1'b1, T, 8'hFF, 8'h00, 1'b0);
    checks++;
    if (if16.q !== 8'h00 || if16.flip_cnt !== 16'd16 || if4.flip_cnt !== 4'd15 || if4.cnt_sat !== 1'b1) begin
      failures++;
      $display("FAIL release2 got q=%h cnt=%0d cnt4=%0d sat4=%b expected q=00 cnt=16 cnt4=15 sat4=1",
               if16.q, if16.flip_cnt, if4.flip_cnt, if4.cnt_sat);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] exp_q [4];
    exp_q = '{8'h0F, 8'h00, 8'h0F, 8'h00};
    step(1'b0, 1'b0, T, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, T, 8'h0F, 8'h00, 1'b0);
      checks++;
      if (if16.q !== exp_q[i] || if16.changed !== 8'h0F) begin
        failures++;
        $display("FAIL toggle_q%0d got q=%h ch=%h expected q=%h ch=0f", i, if16.q, if16.changed, exp_q[i]);
      end
    end
    checks++;
    if (if16.flip_cnt !== 16'd16) begin
      failures++;
      $display("FAIL toggle_cnt got=%0d expected=16", if16.flip_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, T, 8'h0F, 8'h00, 1'b0);
      checks++;
      if (if16.q !== 8'h00 || if16.changed !== 8'h00 || if16.flip_cnt !== 16'd16) begin
        failures++;
        $display("FAIL hold%0d got q=%h ch=%h cnt=%0d expected q=00 ch=00 cnt=16",
                 i, if16.q, if16.changed, if16.flip_cnt);
      end
    end
  endtask

  task automatic test_jk();
    logic [7:0] av [4], bv [4], eq [4], ec [4];
    av = '{8'hF0, 8'h00, 8'hFF, 8'h00};
    bv = '{8'h00, 8'h30, 8'hFF, 8'h00};
    eq = '{8'hF0, 8'hC0, 8'h3F, 8'h3F};
    ec = '{8'hF0, 8'h30, 8'hFF, 8'h00};
    step(1'b0, 1'b0, T, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, JK, av[i], bv[i], 1'b0);
      checks++;
      if (if16.q !== eq[i] || if16.changed !== ec[i]) begin
        failures++;
        $display("FAIL jk%0d got q=%h ch=%h expected q=%h ch=%h", i, if16.q, if16.changed, eq[i], ec[i]);
      end
    end
  endtask

  task automatic test_sr();
    step(1'b0, 1'b0, T, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, D, 8'h5A, 8'h00, 1'b0);
    step(1'b1, 1'b1, SR, 8'h01, 8'h01, 1'b0);
    checks++;
    if (if16.q !== 8'h5A || if16.sr_err !== 1'b1 || if4.sr_err !== 1'b1) begin
      failures++;
      $display("FAIL sr_illegal got q=%h err=%b expected q=5a err=1", if16.q, if16.sr_err);
    end
    step(1'b1, 1'b1, SR, 8'h00, 8'h00, 1'b0);
    checks++;
    if (if16.sr_err !== 1'b1) begin
      failures++;
      $display("FAIL sr_sticky got=%b expected=1", if16.sr_err);
    end
    step(1'b1, 1'b1, SR, 8'h80, 8'h02, 1'b1);
    checks++;
    if (if16.sr_err !== 1'b0 || if16.flip_cnt !== 16'd0 || if16.q !== 8'hD8) begin
      failures++;
      $display("FAIL sr_clear got err=%b cnt=%0d q=%h expected err=0 cnt=0 q=d8",
               if16.sr_err, if16.flip_cnt, if16.q);
    end
    step(1'b1, 1'b1, SR, 8'h04, 8'h04, 1'b1);
    checks++;
    if (if16.sr_err !== 1'b0) begin
      failures++;
      $display("FAIL sr_clear_wins got=%b expected=0", if16.sr_err);
    end
  endtask

  task automatic test_saturation();
    int exp4 [4], exp16 [4];
    logic [7:0] data;
    exp4  = '{8, 15, 15, 15};
    exp16 = '{8, 16, 24, 32};
    step(1'b0, 1'b0, T, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      data = (i % 2 == 0) ? 8'hFF : 8'h00;
      step(1'b1, 1'b1, D, data, 8'h00, 1'b0);
      checks++;
      if (int'(if4.flip_cnt) != exp4[i] || if4.cnt_sat !== (exp4[i] == 15) ||
          int'(if16.flip_cnt) != exp16[i] || if16.cnt_sat !== 1'b0) begin
        failures++;
        $display("FAIL sat%0d got cnt4=%0d sat4=%b cnt16=%0d sat16=%b expected cnt4=%0d cnt16=%0d",
                 i, if4.flip_cnt, if4.cnt_sat, if16.flip_cnt, if16.cnt_sat, exp4[i], exp16[i]);
      end
    end
  endtask

  task automatic test_clr_same_edge();
    step(1'b0, 1'b0, T, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, T, 8'h03, 8'h00, 1'b1);
    checks++;
    if (if16.q !== 8'h03 || if16.changed !== 8'h03 || if16.flip_cnt !== 16'd0) begin
      failures++;
      $display("FAIL clr_edge got q=%h ch=%h cnt=%0d expected q=03 ch=03 cnt=0",
               if16.q, if16.changed, if16.flip_cnt);
    end
    step(1'b1, 1'b1, T, 8'h03, 8'h00, 1'b0);
    checks++;
    if (if16.q !== 8'h00 || if16.flip_cnt !== 16'd2) begin
      failures++;
      $display("FAIL clr_next got q=%h cnt=%0d expected q=00 cnt=2", if16.q, if16.flip_cnt);
    end
  endtask

  task automatic test_random();
    logic [55:0] got, want;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 80), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 99) < 5));
      got  = obs_all();
      want = exp_all();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random%0d got=%h expected=%h", i, got, want);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    m_q = '0; m_ch = '0; m_cnt16 = 0; m_cnt4 = 0;
    m_sat16 = 1'b0; m_sat4 = 1'b0; m_err = 1'b0;
    test_reset();
    test_toggle();
    test_jk();
    test_sr();
    test_saturation();
    test_clr_same_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
